// File: rtl/qpp_interleaver.sv
// qpp_interleaver: stores one turbo code block of K bits (1056 or 6144).
// It then streams the block in natural order on ck and in QPP-interleaved
// order on ck_p, one bit per clock for K cycles.
// The permutation pi(k) = (f1*k + f2*k^2) mod K is generated recursively with adders only.
module qpp_interleaver #(
    parameter int KMAX = 6144,
    parameter int AW   = 13
) (
    input  logic clk,
    input  logic aclr,
    input  logic K,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic data_ready,
    output logic ck,
    output logic ck_p,
    output logic busy,
    output logic K_out
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [AW-1:0] K_SMALL    = AW'(1056);
    localparam logic [AW-1:0] K_LARGE    = AW'(6144);
    localparam logic [AW-1:0] G0_SMALL   = AW'(83);   // (f1 + f2) mod K, f1=17,  f2=66
    localparam logic [AW-1:0] G0_LARGE   = AW'(743);  // (f1 + f2) mod K, f1=263, f2=480
    localparam logic [AW-1:0] STEP_SMALL = AW'(132);  // 2*f2 mod K
    localparam logic [AW-1:0] STEP_LARGE = AW'(960);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic [AW-1:0] pi_reg, pi_next;
    logic [AW-1:0] g_reg, g_next;
    logic          k_sel_reg, k_sel_next;
    logic          armed_reg;
    logic          rd_vld_reg, rd_first_reg;
    logic          ck_reg, ck_p_reg, data_ready_reg;
    logic [AW-1:0] blk_len, g_step;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    rd_bit;

    // Modular add: both operands are below m, so one conditional subtract suffices.
    function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW-1:0] m);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[AW-1:0];
    endfunction

    assign blk_len = k_sel_reg ? K_LARGE : K_SMALL;
    assign g_step  = k_sel_reg ? STEP_LARGE : STEP_SMALL;

    // Next-state logic: one counter serves as write count in LOAD and read index in DRAIN.
    // DRAIN runs K+2 cycles so busy covers the two-stage read pipeline.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pi_next    = pi_reg;
        g_next     = g_reg;
        k_sel_next = k_sel_reg;
        wr_en      = 1'b0;
        wr_addr    = cnt_reg;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                // armed_reg drops in_valid in the first cycle after reset release.
                if (in_valid && armed_reg) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    k_sel_next = K;
                    pi_next    = '0;
                    g_next     = K ? G0_LARGE : G0_SMALL;
                    cnt_next   = AW'(1);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_reg == blk_len - AW'(1)) begin
                        cnt_next   = '0;
                        state_next = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + AW'(1);
                    end
                end
            end
            DRAIN: begin
                cnt_next = cnt_reg + AW'(1);
                if (cnt_reg < blk_len) begin
                    rd_en   = 1'b1;
                    pi_next = add_mod(pi_reg, g_reg, blk_len);
                    g_next  = add_mod(g_reg, g_step, blk_len);
                end
                if (cnt_reg == blk_len + AW'(1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pi_reg    <= '0;
            g_reg     <= '0;
            k_sel_reg <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pi_reg    <= pi_next;
            g_reg     <= g_next;
            k_sel_reg <= k_sel_next;
            armed_reg <= 1'b1;
        end
    end

    // Two identical banks give two read ports: bank 0 reads at k, bank 1 at pi(k).
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic          mem [KMAX];
        logic          rd_q_reg;
        logic [AW-1:0] rd_addr;

        assign rd_addr = (gi == 0) ? cnt_reg : pi_reg;

        // Block RAM write port plus registered read port.
        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_addr] <= in_bit;
            if (rd_en)
                rd_q_reg <= mem[rd_addr];
        end

        assign rd_bit[gi] = rd_q_reg;
    end

    // Output stage: gate RAM data with the read-valid pipeline so idle outputs are 0.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rd_vld_reg     <= 1'b0;
            rd_first_reg   <= 1'b0;
            ck_reg         <= 1'b0;
            ck_p_reg       <= 1'b0;
            data_ready_reg <= 1'b0;
        end else begin
            rd_vld_reg     <= rd_en;
            rd_first_reg   <= rd_en && (cnt_reg == '0);
            ck_reg         <= rd_vld_reg & rd_bit[0];
            ck_p_reg       <= rd_vld_reg & rd_bit[1];
            data_ready_reg <= rd_vld_reg & rd_first_reg;
        end
    end

    assign in_ready   = (state_reg != DRAIN);
    assign busy       = (state_reg != IDLE);
    assign K_out      = k_sel_reg;
    assign ck         = ck_reg;
    assign ck_p       = ck_p_reg;
    assign data_ready = data_ready_reg;

endmodule

// File: tb/tb_qpp_interleaver.sv
// Testbench for qpp_interleaver.
// Expected natural and interleaved streams are pushed to queues at load time.
// They are computed from the closed-form permutation, then popped during drain comparison.
`timescale 1ns/1ps
module tb_qpp_interleaver;

    logic clk = 1'b0;
    logic aclr, K, in_valid, in_bit;
    logic in_ready, data_ready, ck, ck_p, busy, K_out;

    qpp_interleaver #(.KMAX(6144), .AW(13)) dut (
        .clk(clk), .aclr(aclr), .K(K), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .data_ready(data_ready), .ck(ck), .ck_p(ck_p),
        .busy(busy), .K_out(K_out)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   c_data [6144];
    bit   exp_ck [$];
    bit   exp_ckp [$];
    logic obs_ck [6147];
    logic obs_ckp [6147];
    logic obs_dr [6147];
    logic obs_busy [6147];
    logic obs_kout [6147];
    int   cur_k, load_inr_bad, dr_cnt, busy_cnt, inr_drain, kout_bad;
    logic pre_kout, first_kout;

    // Load one block (natural order) with optional random stalls; queue the expected streams.
    task automatic load_block(input bit ksel, input int stall_pct);
        int     f1, f2;
        longint p;
        cur_k = ksel ? 6144 : 1056;
        f1 = ksel ? 263 : 17;
        f2 = ksel ? 480 : 66;
        load_inr_bad = 0;
        pre_kout = K_out;
        for (int i = 0; i < cur_k; i++) begin
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                in_valid = 1'b0;
                K = ~ksel;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if (in_ready !== 1'b1) load_inr_bad++;
            in_valid = 1'b1;
            in_bit   = c_data[i];
            K        = (i == 0) ? ksel : ~ksel;  // K must only matter at the first accept
            @(negedge clk);
            if (i == 0) first_kout = K_out;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        for (int k = 0; k < cur_k; k++) begin
            p = (longint'(f1) * k + longint'(f2) * k * k) % cur_k;
            exp_ck.push_back(c_data[k]);
            exp_ckp.push_back(c_data[int'(p)]);
        end
        $display("load  K=%0d: %0d bits accepted", cur_k, cur_k);
    endtask

    // Capture outputs at the negedge after edges T..T+K+2 (T = last accept edge).
    task automatic drain_capture();
        dr_cnt = 0; busy_cnt = 0; inr_drain = 0; kout_bad = 0;
        for (int n = 0; n <= cur_k + 2; n++) begin
            if (n > 0) @(negedge clk);
            obs_ck[n]   = ck;
            obs_ckp[n]  = ck_p;
            obs_dr[n]   = data_ready;
            obs_busy[n] = busy;
            obs_kout[n] = K_out;
            if (data_ready === 1'b1) dr_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (n <= cur_k + 1 && in_ready !== 1'b0) inr_drain++;
        end
        $display("drain K=%0d: %0d cycles captured, data_ready pulses=%0d", cur_k, cur_k + 3, dr_cnt);
    endtask

    task automatic test_reset();
        aclr = 1'b1; in_valid = 1'b1; in_bit = 1'b1; K = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset in_ready: got %b, want 1", in_ready); end
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset data_ready: got %b, want 0", data_ready); end
        n_checks++; if (ck !== 1'b0)         begin n_fail++; $display("FAIL reset ck: got %b, want 0", ck); end
        n_checks++; if (ck_p !== 1'b0)       begin n_fail++; $display("FAIL reset ck_p: got %b, want 0", ck_p); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset busy: got %b, want 0", busy); end
        n_checks++; if (K_out !== 1'b0)      begin n_fail++; $display("FAIL reset K_out: got %b, want 0", K_out); end
        in_valid = 1'b0; in_bit = 1'b0; K = 1'b0;
        aclr = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_onehot_1056();
        int idx [3];
        int kp [3];
        int ones, pos, ck_ones, ck_pos, mism, bad_k;
        bit e_ck, e_ckp;
        idx = '{83, 298, 49};
        kp  = '{1, 2, 1055};
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 6144; i++) c_data[i] = 1'b0;
            c_data[idx[t]] = 1'b1;
            load_block(1'b0, 0);
            drain_capture();
            ones = 0; pos = -1; ck_ones = 0; ck_pos = -1; mism = 0; bad_k = -1;
            for (int k = 0; k < cur_k; k++) begin
                if (obs_ckp[k+2] === 1'b1) begin ones++; pos = k; end
                if (obs_ck[k+2] === 1'b1) begin ck_ones++; ck_pos = k; end
                e_ck = exp_ck.pop_front();
                e_ckp = exp_ckp.pop_front();
                if (obs_ck[k+2] !== e_ck || obs_ckp[k+2] !== e_ckp) begin
                    mism++; if (bad_k < 0) bad_k = k;
                end
            end
            n_checks++;
            if (ones != 1 || pos != kp[t]) begin
                n_fail++; $display("FAIL onehot1056 c_%0d ck_p: %0d ones, last at k=%0d; want one at k=%0d", idx[t], ones, pos, kp[t]);
            end
            n_checks++;
            if (ck_ones != 1 || ck_pos != idx[t]) begin
                n_fail++; $display("FAIL onehot1056 c_%0d ck: %0d ones, last at k=%0d; want one at k=%0d", idx[t], ck_ones, ck_pos, idx[t]);
            end
            n_checks++;
            if (mism != 0) begin
                n_fail++; $display("FAIL onehot1056 c_%0d stream: %0d bad bits (first k=%0d), want 0", idx[t], mism, bad_k);
            end
        end
    endtask

    task automatic test_spot_6144();
        int idx [2];
        int kp [2];
        int ones, pos, mism, bad_k;
        bit e_ck, e_ckp;
        idx = '{743, 2446};
        kp  = '{1, 2};
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 6144; i++) c_data[i] = 1'b0;
            c_data[idx[t]] = 1'b1;
            load_block(1'b1, 0);
            drain_capture();
            ones = 0; pos = -1; mism = 0; bad_k = -1; kout_bad = 0;
            for (int k = 0; k < cur_k; k++) begin
                if (obs_ckp[k+2] === 1'b1) begin ones++; pos = k; end
                if (obs_kout[k+2] !== 1'b1) kout_bad++;
                e_ck = exp_ck.pop_front();
                e_ckp = exp_ckp.pop_front();
                if (obs_ck[k+2] !== e_ck || obs_ckp[k+2] !== e_ckp) begin
                    mism++; if (bad_k < 0) bad_k = k;
                end
            end
            n_checks++;
            if (ones != 1 || pos != kp[t]) begin
                n_fail++; $display("FAIL spot6144 c_%0d ck_p: %0d ones, last at k=%0d; want one at k=%0d", idx[t], ones, pos, kp[t]);
            end
            n_checks++;
            if (kout_bad != 0) begin
                n_fail++; $display("FAIL spot6144 c_%0d K_out: %0d cycles not 1, want 0", idx[t], kout_bad);
            end
            n_checks++;
            if (mism != 0) begin
                n_fail++; $display("FAIL spot6144 c_%0d stream: %0d bad bits (first k=%0d), want 0", idx[t], mism, bad_k);
            end
        end
    endtask

    task automatic test_stalls();
        int mism, bad_k;
        bit e_ck, e_ckp;
        for (int i = 0; i < 6144; i++) c_data[i] = 1'($urandom_range(1));
        load_block(1'b0, 40);
        drain_capture();
        n_checks++;
        if (load_inr_bad != 0) begin n_fail++; $display("FAIL stalls in_ready during load: %0d low samples, want 0", load_inr_bad); end
        n_checks++;
        if (obs_dr[2] !== 1'b1 || dr_cnt != 1) begin
            n_fail++; $display("FAIL stalls data_ready: at +2=%b, pulses=%0d; want 1 and 1", obs_dr[2], dr_cnt);
        end
        n_checks++;
        if (busy_cnt != cur_k + 2 || obs_busy[cur_k+2] !== 1'b0) begin
            n_fail++; $display("FAIL stalls busy length: %0d cycles, end=%b; want %0d and 0", busy_cnt, obs_busy[cur_k+2], cur_k + 2);
        end
        n_checks++;
        if (inr_drain != 0) begin n_fail++; $display("FAIL stalls in_ready during drain: %0d high samples, want 0", inr_drain); end
        n_checks++;
        if (obs_ck[cur_k+2] !== 1'b0 || obs_ckp[cur_k+2] !== 1'b0) begin
            n_fail++; $display("FAIL stalls tail: ck=%b ck_p=%b, want 0 0", obs_ck[cur_k+2], obs_ckp[cur_k+2]);
        end
        mism = 0; bad_k = -1;
        for (int k = 0; k < cur_k; k++) begin
            e_ck = exp_ck.pop_front();
            e_ckp = exp_ckp.pop_front();
            if (obs_ck[k+2] !== e_ck || obs_ckp[k+2] !== e_ckp) begin mism++; if (bad_k < 0) bad_k = k; end
        end
        n_checks++;
        if (mism != 0) begin n_fail++; $display("FAIL stalls stream: %0d bad bits (first k=%0d), want 0", mism, bad_k); end
    endtask

    task automatic test_back_to_back();
        int ones, pos, mism, bad_k;
        bit e_ck, e_ckp;
        for (int blk = 0; blk < 2; blk++) begin
            if (blk == 0) begin
                for (int i = 0; i < 6144; i++) c_data[i] = 1'b0;
                c_data[217] = 1'b1;
                load_block(1'b1, 0);
            end else begin
                for (int i = 0; i < 6144; i++) c_data[i] = 1'($urandom_range(1));
                load_block(1'b0, 0);   // starts in the first IDLE cycle after the previous drain
                n_checks++;
                if (pre_kout !== 1'b1 || first_kout !== 1'b0) begin
                    n_fail++; $display("FAIL b2b K_out switch: before=%b after first accept=%b; want 1 then 0", pre_kout, first_kout);
                end
            end
            drain_capture();
            ones = 0; pos = -1; mism = 0; bad_k = -1;
            for (int k = 0; k < cur_k; k++) begin
                if (obs_ckp[k+2] === 1'b1) begin ones++; pos = k; end
                e_ck = exp_ck.pop_front();
                e_ckp = exp_ckp.pop_front();
                if (obs_ck[k+2] !== e_ck || obs_ckp[k+2] !== e_ckp) begin mism++; if (bad_k < 0) bad_k = k; end
            end
            if (blk == 0) begin
                n_checks++;
                if (ones != 1 || pos != 6143) begin
                    n_fail++; $display("FAIL b2b c_217 ck_p: %0d ones, last at k=%0d; want one at k=6143", ones, pos);
                end
            end
            n_checks++;
            if (obs_dr[2] !== 1'b1 || dr_cnt != 1) begin
                n_fail++; $display("FAIL b2b blk%0d data_ready: at +2=%b, pulses=%0d; want 1 and 1", blk, obs_dr[2], dr_cnt);
            end
            n_checks++;
            if (mism != 0) begin n_fail++; $display("FAIL b2b blk%0d stream: %0d bad bits (first k=%0d), want 0", blk, mism, bad_k); end
        end
    endtask

    task automatic test_random();
        int mism, bad_k;
        bit e_ck, e_ckp;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 6144; i++) c_data[i] = 1'($urandom_range(1));
            load_block(s == 1, 10);
            drain_capture();
            mism = 0; bad_k = -1;
            for (int k = 0; k < cur_k; k++) begin
                e_ck = exp_ck.pop_front();
                e_ckp = exp_ckp.pop_front();
                if (obs_ck[k+2] !== e_ck || obs_ckp[k+2] !== e_ckp) begin mism++; if (bad_k < 0) bad_k = k; end
            end
            n_checks++;
            if (mism != 0) begin n_fail++; $display("FAIL random K=%0d stream: %0d bad bits (first k=%0d), want 0", cur_k, mism, bad_k); end
            n_checks++;
            if (busy_cnt != cur_k + 2) begin n_fail++; $display("FAIL random K=%0d busy length: %0d, want %0d", cur_k, busy_cnt, cur_k + 2); end
        end
    endtask

    task automatic test_abort();
        int dr_after, mism, bad_k;
        bit e_ck, e_ckp;
        for (int i = 0; i < 6144; i++) c_data[i] = 1'b1;
        load_block(1'b0, 0);
        @(negedge clk); @(negedge clk);   // now at +2: data_ready, ck, ck_p all high
        n_checks++;
        if (data_ready !== 1'b1 || ck !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort pre-state: dr=%b ck=%b busy=%b, want 1 1 1", data_ready, ck, busy);
        end
        #2 aclr = 1'b1;
        #1;
        n_checks++;
        if ({data_ready, ck, ck_p, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL abort outputs: dr/ck/ck_p/busy=%b, want 0000", {data_ready, ck, ck_p, busy});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort in_ready: got %b, want 1", in_ready); end
        exp_ck.delete();
        exp_ckp.delete();
        dr_after = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_ready !== 1'b0) dr_after++;
        end
        n_checks++;
        if (dr_after != 0) begin n_fail++; $display("FAIL abort trailing data_ready: %0d pulses, want 0", dr_after); end
        $display("abort applied mid-drain");
        // Release with in_valid high: that cycle's bit must be ignored.
        aclr = 1'b0; in_valid = 1'b1; in_bit = 1'b1; K = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6144; i++) c_data[i] = 1'($urandom_range(1));
        load_block(1'b0, 0);
        n_checks++;
        if (pre_kout !== 1'b0 || first_kout !== 1'b0) begin
            n_fail++; $display("FAIL abort release bit: K_out before=%b after=%b, want 0 0", pre_kout, first_kout);
        end
        drain_capture();
        mism = 0; bad_k = -1;
        for (int k = 0; k < cur_k; k++) begin
            e_ck = exp_ck.pop_front();
            e_ckp = exp_ckp.pop_front();
            if (obs_ck[k+2] !== e_ck || obs_ckp[k+2] !== e_ckp) begin mism++; if (bad_k < 0) bad_k = k; end
        end
        n_checks++;
        if (mism != 0) begin n_fail++; $display("FAIL abort next-block stream: %0d bad bits (first k=%0d), want 0", mism, bad_k); end
    endtask

    initial begin
        aclr = 1'b1; K = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        test_reset();
        test_onehot_1056();
        test_spot_6144();
        test_stalls();
        test_back_to_back();
        test_random();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qpp_interleaver.md
# qpp_interleaver

Upstream feeder for the turbo encoder pair. Collects one code block of K systematic bits (K = 1056 or 6144) serially, stores it, then streams it out twice in lockstep: natural order to the first constituent encoder and QPP-interleaved order to the second. Output timing matches the constituent encoder's input contract:
- `data_ready` is a one-cycle pulse.
- One bit per `clk` follows for exactly K cycles.

## Interface
Parameters:
- `KMAX`, 6144: storage depth in bits.
- `AW`, 13: address and arithmetic width; must satisfy 2^AW > KMAX.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `aclr`  in  1  reset, asynchronous, active-high; returns the block to IDLE.
- `K`  in  1  block size select: 0 = 1056, 1 = 6144. Sampled only on the IDLE→LOAD transition.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  systematic input bit c_i, natural order.
- `in_ready`  out  1  block accepts input this cycle.
- `data_ready`  out  1  one-cycle pulse, coincident with output bit k = 0.
- `ck`  out  1  natural-order bit c_k, to encoder 1.
- `ck_p`  out  1  interleaved bit c_pi(k), to encoder 2.
- `busy`  out  1  high in LOAD and DRAIN.
- `K_out`  out  1  latched block size, forwarded to both encoders' `K`.

## Operation
Reset state, held while `aclr` is high: state IDLE, all counters 0. Outputs: `in_ready` = 1, `data_ready` = 0, `ck` = 0, `ck_p` = 0, `busy` = 0, `K_out` = 0.

- **IDLE**
  - First `in_valid` = 1 latches `K` into `K_out`.
  - Selects the size set:
    - K = 1056: f1 = 17, f2 = 66, 2f2 mod K = 132.
    - K = 6144: f1 = 263, f2 = 480, 2f2 mod K = 960.
  - Writes `in_bit` at address 0 and enters LOAD with write count = 1.
- **LOAD**
  - Each `in_valid` cycle writes `in_bit` at address = write count, then increments the count.
  - Cycles with `in_valid` = 0 are stalls: no write, no state change.
  - The write that brings the count to K moves the state to DRAIN.
  - `in_ready` = 1 throughout LOAD.
- **DRAIN**
  - `in_ready` = 0; `in_valid` and `in_bit` are ignored.
  - Outputs bits for k = 0..K−1 on K consecutive cycles; no stalls are permitted.
  - After k = K−1, returns to IDLE with `ck` = `ck_p` = 0.
  - `K_out` holds its value until the next IDLE→LOAD transition.
- **Address generation**
  - Permutation: pi(k) = (f1·k + f2·k²) mod K, computed recursively with no multiplier.
  - Initial values: pi(0) = 0, g(0) = (f1 + f2) mod K (83 for 1056, 743 for 6144).
  - Per step: pi(k+1) = pi(k) + g(k) mod K; g(k+1) = g(k) + 2f2 mod K.
  - Each mod is one conditional subtract of K, since both operands are < K. Adders are AW+1 bits wide.
- **Storage**: one KMAX×1 array.
  - Natural read port at k, interleaved read port at pi(k).
  - Two read ports are required; duplicating the array is acceptable.
  - Read is synchronous; addresses are generated one cycle ahead, so outputs are registered.

## Timing
- The last LOAD write occurs at edge T, i.e. the K-th accepted bit, counting the IDLE write.
- Edge T+1: state is DRAIN and the first reads are issued.
- Edge T+2: `data_ready` = 1, `ck` = c_0, `ck_p` = c_pi(0) = c_0.
- Edge T+2+k: `ck` = c_k, `ck_p` = c_pi(k), for k = 0..K−1.
- `data_ready` is high for exactly one cycle, from edge T+2 to T+3.
- Edge T+2+K: `ck` = `ck_p` = 0 and the state is IDLE. `busy` falls at this same edge.
- Latency: 2 cycles from the final input accept to the first output bit.
- Throughput: K input cycles (no stalls) + 2 + K output cycles per block.
- `aclr` asserted mid-LOAD or mid-DRAIN aborts immediately:
  - outputs go to reset values with no trailing `data_ready`;
  - partial block contents are discarded, and array contents need not be cleared.
- `in_valid` asserted in the same cycle that `aclr` deasserts is ignored. The first accepted bit is at the next edge.

## Test plan
- **Reset**: assert `aclr` mid-DRAIN → `data_ready` = `ck` = `ck_p` = `busy` = 0 within the same cycle; `in_ready` = 1; next block loads normally.
- **K=1056 one-hot**:
  - Stimulus: c_83 = 1, all others 0.
  - Response: `ck_p` = 1 only at k = 1; `ck` = 1 only at k = 83.
  - Repeat with c_298 = 1 → `ck_p` = 1 only at k = 2.
- **K=1056 last index**: c_49 = 1 → `ck_p` = 1 only at k = 1055.
- **K=6144 spot checks**:
  - c_743 = 1 → `ck_p` at k = 1.
  - c_2446 = 1 → `ck_p` at k = 2.
  - c_217 = 1 → `ck_p` at k = 6143.
  - `K_out` = 1 throughout.
- **Handshake and stalls**:
  - Stimulus: K=1056 loaded with random `in_valid` gaps.
  - Response: `data_ready` exactly 2 cycles after the 1056th accept; exactly 1056 output cycles; `in_ready` = 0 throughout DRAIN.
- **Back-to-back blocks**:
  - Stimulus: 6144 block, then a 1056 block started the cycle IDLE is re-entered.
  - Response: second block uses the 1056 coefficients; `K_out` changes 1→0 at the second block's first accept.
- **Random permutation check**: random data, both K → every `ck_p` matches the reference model c[(f1·k + f2·k²) mod K].
